// File: rtl/rr_stream_arbiter_if.sv
// Handshake bundle for rr_stream_arbiter: N_REQ requester streams in, one tagged stream out.
// The slave modport is the arbiter side; master is the producer/consumer side.
// Build option: RR_ARB_PACKET_LOCK_EN adds req_last/out_last packet framing.
interface rr_stream_arbiter_if #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_W-1:0]       out_data;
  logic [ID_W-1:0]         out_id;
`ifdef RR_ARB_PACKET_LOCK_EN
  logic [N_REQ-1:0]        req_last;
  logic                    out_last;

  modport slave (
    input  req_valid, req_data, req_last, out_ready,
    output req_ready, out_valid, out_data, out_id, out_last
  );
  modport master (
    output req_valid, req_data, req_last, out_ready,
    input  req_ready, out_valid, out_data, out_id, out_last
  );
`else
  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_id
  );
  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_id
  );
`endif
endinterface

// File: rtl/rr_stream_arbiter.sv
// N-to-1 round-robin arbiter feeding a single-entry registered output slot.
// Each beat is tagged with the index of the requester that sent it.
// Build option: RR_ARB_PACKET_LOCK_EN holds the grant on one requester until it
// delivers a beat with req_last=1, so rotation happens per packet instead of per beat.
module rr_stream_arbiter #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  rr_stream_arbiter_if.slave bus
);
  localparam int unsigned ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  // Reset value of last_grant so that requester 0 is scanned first.
  localparam logic [ID_W-1:0] LastIdx = ID_W'(N_REQ - 1);

  logic              full_q, full_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d;

  logic              slot_free;
  logic              found;
  logic              accept;
  logic [ID_W-1:0]   win;
  logic [DATA_W-1:0] win_data;
  logic [N_REQ-1:0]  ready;

`ifdef RR_ARB_PACKET_LOCK_EN
  typedef enum logic [0:0] {StFree, StLocked} lock_e;

  lock_e           lock_q, lock_d;
  logic [ID_W-1:0] lock_id_q, lock_id_d;
  logic            last_q, last_d;
`endif

  // Index of the k-th candidate after base, wrapping modulo N_REQ.
  function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int unsigned k);
    int unsigned s;
    s = (32'(base) + 32'd1 + k) % N_REQ;
    return ID_W'(s);
  endfunction

  // The slot can take a new beat when empty or when its current beat leaves this cycle.
  assign slot_free = !full_q || bus.out_ready;

  // Pick the first valid requester after last_grant (or the locked owner).
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!found && bus.req_valid[rr_idx(last_grant_q, k)]) begin
        found = 1'b1;
        win   = rr_idx(last_grant_q, k);
      end
    end
`ifdef RR_ARB_PACKET_LOCK_EN
    // Mid-packet: nobody but the owner may be granted, even if the owner is idle.
    if (lock_q == StLocked) begin
      found = bus.req_valid[lock_id_q];
      win   = lock_id_q;
    end
`endif
  end

  // Grant is a single ready bit, suppressed during reset and while the slot is blocked.
  always_comb begin
    accept = found && slot_free && !rst;
    ready  = '0;
    if (accept) begin
      ready[win] = 1'b1;
    end
    win_data = bus.req_data[32'(win) * DATA_W +: DATA_W];
  end

  assign bus.req_ready = ready;
  assign bus.out_valid = full_q;
  assign bus.out_data  = data_q;
  assign bus.out_id    = id_q;
`ifdef RR_ARB_PACKET_LOCK_EN
  assign bus.out_last  = last_q;
`endif

  // Next-state: fill on accept (overrides a simultaneous drain), otherwise drain.
  always_comb begin
    full_d       = full_q;
    data_d       = data_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
`ifdef RR_ARB_PACKET_LOCK_EN
    lock_d       = lock_q;
    lock_id_d    = lock_id_q;
    last_d       = last_q;
`endif
    if (accept) begin
      full_d = 1'b1;
      data_d = win_data;
      id_d   = win;
`ifdef RR_ARB_PACKET_LOCK_EN
      last_d = bus.req_last[win];
      if (bus.req_last[win]) begin
        lock_d       = StFree;
        last_grant_d = win;
      end else begin
        lock_d    = StLocked;
        lock_id_d = win;
      end
`else
      last_grant_d = win;
`endif
    end else if (full_q && bus.out_ready) begin
      full_d = 1'b0;
    end
  end

  // State registers with synchronous reset; a buffered beat is dropped on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q       <= 1'b0;
      data_q       <= '0;
      id_q         <= '0;
      last_grant_q <= LastIdx;
`ifdef RR_ARB_PACKET_LOCK_EN
      lock_q       <= StFree;
      lock_id_q    <= '0;
      last_q       <= 1'b0;
`endif
    end else begin
      full_q       <= full_d;
      data_q       <= data_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
`ifdef RR_ARB_PACKET_LOCK_EN
      lock_q       <= lock_d;
      lock_id_q    <= lock_id_d;
      last_q       <= last_d;
`endif
    end
  end
endmodule
